// File: rtl/footies_pkg.sv
// Shared definitions for the fighting-game core: state and winner encodings,
// counter width, and the freeze decode used by the match sequencer.
package footies_pkg;

  localparam int COUNTER_W = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN  = 3'd1;
  localparam logic [2:0] ST_FIGHT      = 3'd2;
  localparam logic [2:0] ST_HITSTOP    = 3'd3;
  localparam logic [2:0] ST_ROUND_OVER = 3'd4;
  localparam logic [2:0] ST_MATCH_OVER = 3'd5;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_COUNTDOWN  = ST_COUNTDOWN,
    S_FIGHT      = ST_FIGHT,
    S_HITSTOP    = ST_HITSTOP,
    S_ROUND_OVER = ST_ROUND_OVER,
    S_MATCH_OVER = ST_MATCH_OVER
  } state_e;

  // Wait states are exactly the states in which gameplay motion is frozen.
  function automatic logic is_wait_state(input state_e s);
    logic r;
    case (s)
      S_COUNTDOWN, S_HITSTOP, S_ROUND_OVER: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Tick-driven down-counter shared by all wait states; done_o flags the tick
// that consumes the last remaining frame.
module frame_timer
  import footies_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic                 tick_i,
  input  logic                 load_i,
  input  logic [COUNTER_W-1:0] value_i,
  output logic                 done_o
);

  logic [COUNTER_W-1:0] count_q;
  logic [COUNTER_W-1:0] count_d;

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= {COUNTER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // A reload wins over a same-cycle tick so a new wait starts from a full count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (en_i && tick_i && (count_q != {COUNTER_W{1'b0}})) begin
      count_d = count_q - {{(COUNTER_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  assign done_o = en_i & tick_i & (count_q == {{(COUNTER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: gates hits into pulses during FIGHT, applies hit-stop,
// tallies round wins and re-arms health between rounds.
module match_controller
  import footies_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned HITSTOP_FRAMES   = 12,
  parameter int unsigned ROUND_END_FRAMES = 120,
  parameter int unsigned ROUNDS_TO_WIN    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       hit1_req,
  input  logic       hit2_req,
  input  logic       game_over1,
  input  logic       game_over2,
  output logic       hit1_lands,
  output logic       hit2_lands,
  output logic       health_reset,
  output logic       freeze,
  output logic [2:0] state,
  output logic [1:0] rounds1,
  output logic [1:0] rounds2,
  output logic [1:0] match_winner
);

  localparam logic [COUNTER_W-1:0] CD_LOAD  = COUNTER_W'(COUNTDOWN_FRAMES);
  localparam logic [COUNTER_W-1:0] HS_LOAD  = COUNTER_W'(HITSTOP_FRAMES);
  localparam logic [COUNTER_W-1:0] RE_LOAD  = COUNTER_W'(ROUND_END_FRAMES);
  localparam logic [1:0]           WIN_CNT  = 2'(ROUNDS_TO_WIN);

  state_e     state_q, state_d;
  logic       hit1_q, hit1_d;
  logic       hit2_q, hit2_d;
  logic       hreset_q, hreset_d;
  logic       freeze_q, freeze_d;
  logic [1:0] rounds1_q, rounds1_d;
  logic [1:0] rounds2_q, rounds2_d;
  logic [1:0] winner_q, winner_d;

  logic                 timer_en_s;
  logic                 timer_load_s;
  logic [COUNTER_W-1:0] timer_val_s;
  logic                 timer_done_s;

  assign timer_en_s = is_wait_state(state_q);

  frame_timer u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (timer_en_s),
    .tick_i  (tick),
    .load_i  (timer_load_s),
    .value_i (timer_val_s),
    .done_o  (timer_done_s)
  );

  // State and output registers; reset clears everything with no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      hreset_q  <= 1'b0;
      freeze_q  <= 1'b0;
      rounds1_q <= 2'b00;
      rounds2_q <= 2'b00;
      winner_q  <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      hit1_q    <= hit1_d;
      hit2_q    <= hit2_d;
      hreset_q  <= hreset_d;
      freeze_q  <= freeze_d;
      rounds1_q <= rounds1_d;
      rounds2_q <= rounds2_d;
      winner_q  <= winner_d;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    hit1_d       = 1'b0;
    hit2_d       = 1'b0;
    hreset_d     = 1'b0;
    rounds1_d    = rounds1_q;
    rounds2_d    = rounds2_q;
    winner_d     = winner_q;
    timer_load_s = 1'b0;
    timer_val_s  = {COUNTER_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (start_btn) begin
          hreset_d     = 1'b1;
          timer_load_s = 1'b1;
          timer_val_s  = CD_LOAD;
          state_d      = S_COUNTDOWN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNTDOWN: begin
        if (timer_done_s) begin
          state_d = S_FIGHT;
        end else begin
          state_d = S_COUNTDOWN;
        end
      end
      S_FIGHT: begin
        if (hit1_req || hit2_req) begin
          hit1_d       = hit1_req;
          hit2_d       = hit2_req;
          timer_load_s = 1'b1;
          timer_val_s  = HS_LOAD;
          state_d      = S_HITSTOP;
        end else begin
          state_d = S_FIGHT;
        end
      end
      S_HITSTOP: begin
        if (timer_done_s) begin
          if (game_over1 || game_over2) begin
            // A double KO is a draw and awards nothing.
            if (game_over2 && !game_over1 && (rounds1_q < WIN_CNT)) begin
              rounds1_d = rounds1_q + 2'b01;
            end else if (game_over1 && !game_over2 && (rounds2_q < WIN_CNT)) begin
              rounds2_d = rounds2_q + 2'b01;
            end else begin
              rounds1_d = rounds1_q;
            end
            timer_load_s = 1'b1;
            timer_val_s  = RE_LOAD;
            state_d      = S_ROUND_OVER;
          end else begin
            state_d = S_FIGHT;
          end
        end else begin
          state_d = S_HITSTOP;
        end
      end
      S_ROUND_OVER: begin
        if (timer_done_s) begin
          if (rounds1_q == WIN_CNT) begin
            winner_d = WIN_P1;
            state_d  = S_MATCH_OVER;
          end else if (rounds2_q == WIN_CNT) begin
            winner_d = WIN_P2;
            state_d  = S_MATCH_OVER;
          end else begin
            hreset_d     = 1'b1;
            timer_load_s = 1'b1;
            timer_val_s  = CD_LOAD;
            state_d      = S_COUNTDOWN;
          end
        end else begin
          state_d = S_ROUND_OVER;
        end
      end
      S_MATCH_OVER: begin
        if (start_btn) begin
          rounds1_d    = 2'b00;
          rounds2_d    = 2'b00;
          winner_d     = WIN_NONE;
          hreset_d     = 1'b1;
          timer_load_s = 1'b1;
          timer_val_s  = CD_LOAD;
          state_d      = S_COUNTDOWN;
        end else begin
          state_d = S_MATCH_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    freeze_d = is_wait_state(state_d);
  end

  assign hit1_lands   = hit1_q;
  assign hit2_lands   = hit2_q;
  assign health_reset = hreset_q;
  assign freeze       = freeze_q;
  assign state        = state_q;
  assign rounds1      = rounds1_q;
  assign rounds2      = rounds2_q;
  assign match_winner = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with short frame counts and a tick
// every 4 clocks; expected values are hand-derived constants.
module tb_match_controller;

  localparam logic [2:0] E_IDLE = 3'd0, E_CD = 3'd1, E_FIGHT = 3'd2;
  localparam logic [2:0] E_HS = 3'd3, E_RO = 3'd4, E_MO = 3'd5;

  logic clk = 1'b0;
  logic reset, tick, start_btn, hit1_req, hit2_req, game_over1, game_over2;
  logic hit1_lands, hit2_lands, health_reset, freeze;
  logic [2:0] state;
  logic [1:0] rounds1, rounds2, match_winner;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int ph = 0, tick_en = 0;
  int run_ticks = 0, exit_ticks = 0, exit_on_tick = 0;
  int n_h1 = 0, n_h2 = 0, n_hr = 0;

  match_controller #(
    .COUNTDOWN_FRAMES(3), .HITSTOP_FRAMES(2), .ROUND_END_FRAMES(2), .ROUNDS_TO_WIN(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn),
    .hit1_req(hit1_req), .hit2_req(hit2_req),
    .game_over1(game_over1), .game_over2(game_over2),
    .hit1_lands(hit1_lands), .hit2_lands(hit2_lands), .health_reset(health_reset),
    .freeze(freeze), .state(state), .rounds1(rounds1), .rounds2(rounds2),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, then schedule the next tick.
  task automatic step();
    logic [2:0] s0;
    logic t;
    s0 = state;
    t = tick;
    @(posedge clk);
    #1;
    if (state != s0) begin
      exit_ticks = run_ticks + (t ? 1 : 0);
      exit_on_tick = t ? 1 : 0;
      run_ticks = 0;
    end else if (t) begin
      run_ticks++;
    end
    if (hit1_lands) n_h1++;
    if (hit2_lands) n_h2++;
    if (health_reset) n_hr++;
    if (tick_en != 0) begin
      ph = (ph == 3) ? 0 : ph + 1;
      tick = (ph == 3);
    end else begin
      tick = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_exit(input string tag);
    logic [2:0] s;
    int c;
    s = state;
    c = 0;
    while (state == s && c < 200) begin
      step();
      c++;
    end
    chk({tag, "_timeout"}, 16'(c < 200), 16'd1);
  endtask

  task automatic clr_cnt();
    n_h1 = 0; n_h2 = 0; n_hr = 0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start_btn = 1'b0; hit1_req = 1'b0; hit2_req = 1'b0;
    game_over1 = 1'b0; game_over2 = 1'b0;
    steps(2);
    reset = 1'b0;
    chk("reset_state", 16'(state), 16'(E_IDLE));
    chk("reset_outs", {6'd0, hit1_lands, hit2_lands, health_reset, freeze,
                       rounds1, rounds2, match_winner}, 16'd0);

    // Start: single health_reset pulse, countdown of 3 ticks; hits ignored.
    tick_en = 1; start_btn = 1'b1; clr_cnt();
    step();
    start_btn = 1'b0;
    chk("start_state", 16'(state), 16'(E_CD));
    chk("start_hreset_freeze", {14'd0, health_reset, freeze}, 16'b11);
    hit1_req = 1'b1; hit2_req = 1'b1;
    steps(2);
    hit1_req = 1'b0; hit2_req = 1'b0;
    chk("hreset_one_cycle", 16'(health_reset), 16'd0);
    wait_exit("cd1");
    chk("cd1_state", 16'(state), 16'(E_FIGHT));
    chk("cd1_ticks", 16'(exit_ticks * 2 + exit_on_tick), 16'd7);
    chk("cd_hits_dropped", 16'(n_h1 + n_h2), 16'd0);
    chk("cd_hreset_count", 16'(n_hr), 16'd1);
    chk("fight_freeze", 16'(freeze), 16'd0);

    // Single hit: one pulse, HITSTOP, second player's request dropped.
    clr_cnt(); hit1_req = 1'b1;
    step();
    hit1_req = 1'b0;
    chk("hit1_pulse", {13'd0, hit1_lands, hit2_lands, freeze}, 16'b101);
    chk("hit1_state", 16'(state), 16'(E_HS));
    hit2_req = 1'b1;
    step();
    chk("hit1_one_cycle", 16'(hit1_lands), 16'd0);
    step();
    hit2_req = 1'b0;
    wait_exit("hs1");
    chk("hs1_state", 16'(state), 16'(E_FIGHT));
    chk("hs1_ticks", 16'(exit_ticks * 2 + exit_on_tick), 16'd5);
    chk("hs1_pulses", 16'(n_h1 * 16 + n_h2), 16'h10);

    // Trade with both at 1 health: draw, no award, fresh countdown.
    hit1_req = 1'b1; hit2_req = 1'b1;
    step();
    hit1_req = 1'b0; hit2_req = 1'b0;
    chk("trade_pulses", {14'd0, hit1_lands, hit2_lands}, 16'b11);
    game_over1 = 1'b1; game_over2 = 1'b1;
    wait_exit("hs_draw");
    chk("draw_state", 16'(state), 16'(E_RO));
    chk("draw_rounds", {12'd0, rounds1, rounds2}, 16'd0);
    wait_exit("ro_draw");
    chk("draw_recd", {12'd0, state, health_reset}, {12'd0, E_CD, 1'b1});
    chk("ro_ticks", 16'(exit_ticks * 2 + exit_on_tick), 16'd5);
    game_over1 = 1'b0; game_over2 = 1'b0;
    wait_exit("cd2");

    // P1 wins two rounds with three hits.
    hit1_req = 1'b1; step(); hit1_req = 1'b0;
    wait_exit("hs_a");
    chk("no_ko_fight", 16'(state), 16'(E_FIGHT));
    hit1_req = 1'b1; step(); hit1_req = 1'b0;
    game_over2 = 1'b1;
    wait_exit("hs_b");
    chk("round1_award", {10'd0, state, rounds1, rounds2}, {10'd0, E_RO, 2'd1, 2'd0});
    wait_exit("ro_b");
    chk("round2_cd", {12'd0, state, health_reset}, {12'd0, E_CD, 1'b1});
    game_over2 = 1'b0;
    wait_exit("cd3");
    hit1_req = 1'b1; step(); hit1_req = 1'b0;
    game_over2 = 1'b1;
    wait_exit("hs_c");
    chk("round2_award", {12'd0, rounds1, rounds2}, {12'd0, 2'd2, 2'd0});
    wait_exit("ro_c");
    chk("match_over", {9'd0, state, freeze, match_winner, rounds1}, {9'd0, E_MO, 1'b0, 2'b01, 2'd2});
    steps(20);
    chk("match_hold", 16'(state), 16'(E_MO));
    game_over2 = 1'b0;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("restart", {9'd0, state, health_reset, rounds1, rounds2},
                   {9'd0, E_CD, 1'b1, 2'd0, 2'd0});
    chk("restart_winner", 16'(match_winner), 16'd0);

    // Tick held low: countdown must not advance.
    tick_en = 0; tick = 1'b0;
    steps(100);
    chk("tick_hold", 16'(state), 16'(E_CD));
    tick_en = 1;
    wait_exit("cd4");
    chk("cd4_ticks", {12'd0, state, 1'(exit_on_tick)}, {12'd0, E_FIGHT, 1'b1});
    chk("cd4_count", 16'(exit_ticks), 16'd3);

    // Reset in the middle of HITSTOP with live requests on the reset edge.
    hit2_req = 1'b1; step(); hit2_req = 1'b0;
    chk("hit2_pulse", {12'd0, state, hit2_lands}, {12'd0, E_HS, 1'b1});
    step();
    clr_cnt();
    reset = 1'b1; hit1_req = 1'b1; start_btn = 1'b1;
    step();
    chk("midreset_state", 16'(state), 16'(E_IDLE));
    chk("midreset_outs", {6'd0, hit1_lands, hit2_lands, health_reset, freeze,
                          rounds1, rounds2, match_winner}, 16'd0);
    reset = 1'b0; hit1_req = 1'b0; start_btn = 1'b0;
    steps(10);
    chk("midreset_quiet", 16'(n_h1 + n_h2 + n_hr), 16'd0);
    chk("midreset_idle", 16'(state), 16'(E_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
